// File: rtl/hazard_ctrl_pkg.sv
// Shared constants for the hazard controller: default widths and the
// forwarding-select encoding used by every operand mux.
package hazard_ctrl_pkg;

    localparam int unsigned AW_DEF = 5;
    localparam int unsigned TW_DEF = 3;

    // Forward select: 0 = regfile / pipeline register, else the producing stage
    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_W    = 2'd1,
        FWD_M    = 2'd2,
        FWD_E    = 2'd3
    } fwd_sel_e;

endpackage

// File: rtl/hazard_ctrl_fwd_pick.sv
// Forwarding select for one operand: the nearest stage writing the operand's
// register decides; it is used only if its result already exists.
module fwd_pick
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned AW    = AW_DEF,
    parameter int unsigned TW    = TW_DEF,
    parameter int unsigned NCAND = 3
) (
    input  logic [AW-1:0]             i_addr,
    input  logic [NCAND-1:0][AW-1:0]  i_a3,    // index 0 = nearest stage
    input  logic [NCAND-1:0][TW-1:0]  i_tnew,
    input  logic [NCAND-1:0][1:0]     i_code,
    output logic [1:0]                o_sel
);

    // Walk oldest to nearest so the nearest match overrides; a not-ready
    // nearest producer forces 0 rather than exposing an older stale value.
    always_comb begin
        o_sel = FWD_NONE;
        for (int unsigned k = 0; k < NCAND; k++) begin
            if (i_a3[NCAND-1-k] == i_addr) begin
                o_sel = (i_tnew[NCAND-1-k] == '0) ? i_code[NCAND-1-k] : FWD_NONE;
            end
        end
        if (i_addr == '0) begin
            o_sel = FWD_NONE;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks destination/Tnew through E, M, W,
// raises a same-cycle stall and drives the five forwarding selects.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned TW = TW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] A1_D,
    input  logic [AW-1:0] A2_D,
    input  logic [AW-1:0] A3_D,
    input  logic [TW-1:0] Tuse1_D,
    input  logic [TW-1:0] Tuse2_D,
    input  logic [TW-1:0] Tnew_D,
    output logic          stall,
    output logic          pc_en,
    output logic          d_en,
    output logic          e_clr,
    output logic [1:0]    fwd_rs_D,
    output logic [1:0]    fwd_rt_D,
    output logic [1:0]    fwd_rs_E,
    output logic [1:0]    fwd_rt_E,
    output logic [1:0]    fwd_rt_M
);

    // Only the read addresses that some mux consumes are kept downstream:
    // A1 stops at E, A2 stops at M (store data); no output depends on the rest.
    logic [AW-1:0] r_a1_e, r_a2_e, r_a3_e;
    logic [TW-1:0] r_tnew_e;
    logic [AW-1:0] r_a2_m, r_a3_m;
    logic [TW-1:0] r_tnew_m;
    logic [AW-1:0] r_a3_w;
    logic [TW-1:0] r_tnew_w;

    logic w_stall;

    // Stall when a D read is needed before an E or M producer has its result
    always_comb begin
        w_stall = 1'b0;
        if (A1_D != '0 && A1_D == r_a3_e && Tuse1_D < r_tnew_e) w_stall = 1'b1;
        if (A1_D != '0 && A1_D == r_a3_m && Tuse1_D < r_tnew_m) w_stall = 1'b1;
        if (A2_D != '0 && A2_D == r_a3_e && Tuse2_D < r_tnew_e) w_stall = 1'b1;
        if (A2_D != '0 && A2_D == r_a3_m && Tuse2_D < r_tnew_m) w_stall = 1'b1;
    end

    assign stall = w_stall;
    assign pc_en = ~w_stall;
    assign d_en  = ~w_stall;
    assign e_clr = w_stall;

    // Stage shift: E takes D (or a bubble on stall), M and W age Tnew toward 0
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a1_e   <= '0;
            r_a2_e   <= '0;
            r_a3_e   <= '0;
            r_tnew_e <= '0;
            r_a2_m   <= '0;
            r_a3_m   <= '0;
            r_tnew_m <= '0;
            r_a3_w   <= '0;
            r_tnew_w <= '0;
        end else begin
            r_a2_m   <= r_a2_e;
            r_a3_m   <= r_a3_e;
            r_tnew_m <= (r_tnew_e == '0) ? '0 : r_tnew_e - TW'(1);
            r_a3_w   <= r_a3_m;
            r_tnew_w <= (r_tnew_m == '0) ? '0 : r_tnew_m - TW'(1);
            if (w_stall) begin
                r_a1_e   <= '0;
                r_a2_e   <= '0;
                r_a3_e   <= '0;
                r_tnew_e <= '0;
            end else begin
                r_a1_e   <= A1_D;
                r_a2_e   <= A2_D;
                r_a3_e   <= A3_D;
                r_tnew_e <= Tnew_D;
            end
        end
    end

    fwd_pick #(.AW(AW), .TW(TW), .NCAND(3)) u_fwd_rs_d (
        .i_addr (A1_D),
        .i_a3   ({r_a3_w, r_a3_m, r_a3_e}),
        .i_tnew ({r_tnew_w, r_tnew_m, r_tnew_e}),
        .i_code ({FWD_W, FWD_M, FWD_E}),
        .o_sel  (fwd_rs_D)
    );

    fwd_pick #(.AW(AW), .TW(TW), .NCAND(3)) u_fwd_rt_d (
        .i_addr (A2_D),
        .i_a3   ({r_a3_w, r_a3_m, r_a3_e}),
        .i_tnew ({r_tnew_w, r_tnew_m, r_tnew_e}),
        .i_code ({FWD_W, FWD_M, FWD_E}),
        .o_sel  (fwd_rt_D)
    );

    fwd_pick #(.AW(AW), .TW(TW), .NCAND(2)) u_fwd_rs_e (
        .i_addr (r_a1_e),
        .i_a3   ({r_a3_w, r_a3_m}),
        .i_tnew ({r_tnew_w, r_tnew_m}),
        .i_code ({FWD_W, FWD_M}),
        .o_sel  (fwd_rs_E)
    );

    fwd_pick #(.AW(AW), .TW(TW), .NCAND(2)) u_fwd_rt_e (
        .i_addr (r_a2_e),
        .i_a3   ({r_a3_w, r_a3_m}),
        .i_tnew ({r_tnew_w, r_tnew_m}),
        .i_code ({FWD_W, FWD_M}),
        .o_sel  (fwd_rt_E)
    );

    fwd_pick #(.AW(AW), .TW(TW), .NCAND(1)) u_fwd_rt_m (
        .i_addr (r_a2_m),
        .i_a3   (r_a3_w),
        .i_tnew (r_tnew_w),
        .i_code (FWD_W),
        .o_sel  (fwd_rt_M)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed MIPS hazard scenarios followed by random
// traffic, all checked against an age-indexed instruction history model.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] A1_D, A2_D, A3_D;
    logic [2:0] Tuse1_D, Tuse2_D, Tnew_D;
    logic       stall, pc_en, d_en, e_clr;
    logic [1:0] fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M;

    hazard_ctrl #(.AW(5), .TW(3)) dut (
        .clk(clk), .reset(reset),
        .A1_D(A1_D), .A2_D(A2_D), .A3_D(A3_D),
        .Tuse1_D(Tuse1_D), .Tuse2_D(Tuse2_D), .Tnew_D(Tnew_D),
        .stall(stall), .pc_en(pc_en), .d_en(d_en), .e_clr(e_clr),
        .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D),
        .fwd_rs_E(fwd_rs_E), .fwd_rt_E(fwd_rt_E), .fwd_rt_M(fwd_rt_M)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instruction history: hist[g] is the instruction that left D g cycles ago
    // (1 = E, 2 = M, 3 = W). Bubbles are all-zero records.
    typedef struct {
        int a1, a2, a3, tnew;
    } rec_t;
    rec_t hist [1:3];

    // Values seen at the last non-stalled sample of a step
    logic       smp_stall;
    logic [1:0] smp_rsD, smp_rtD, smp_rsE, smp_rtE, smp_rtM;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void clear_hist();
        for (int g = 1; g <= 3; g++) hist[g] = '{0, 0, 0, 0};
    endfunction

    // Cycles still needed by the instruction of age g
    function automatic int rem(input int g);
        int t;
        t = hist[g].tnew - (g - 1);
        return (t < 0) ? 0 : t;
    endfunction

    // Nearest producer among ages g_lo..3 decides; code is 4-age (E=3, M=2, W=1)
    function automatic int pick(input int addr, input int g_lo);
        if (addr == 0) return 0;
        for (int g = g_lo; g <= 3; g++) begin
            if (hist[g].a3 == addr) return (rem(g) == 0) ? (4 - g) : 0;
        end
        return 0;
    endfunction

    function automatic bit m_stall(input int a1, input int a2, input int u1, input int u2);
        bit s = 1'b0;
        for (int g = 1; g <= 2; g++) begin
            if (a1 != 0 && a1 == hist[g].a3 && u1 < rem(g)) s = 1'b1;
            if (a2 != 0 && a2 == hist[g].a3 && u2 < rem(g)) s = 1'b1;
        end
        return s;
    endfunction

    task automatic check_all(input int a1, input int a2, input int u1, input int u2, output bit s);
        s = m_stall(a1, a2, u1, u2);
        chk("stall",    8'(stall),    8'(s));
        chk("pc_en",    8'(pc_en),    8'(!s));
        chk("d_en",     8'(d_en),     8'(!s));
        chk("e_clr",    8'(e_clr),    8'(s));
        chk("fwd_rs_D", 8'(fwd_rs_D), 8'(pick(a1, 1)));
        chk("fwd_rt_D", 8'(fwd_rt_D), 8'(pick(a2, 1)));
        chk("fwd_rs_E", 8'(fwd_rs_E), 8'(pick(hist[1].a1, 2)));
        chk("fwd_rt_E", 8'(fwd_rt_E), 8'(pick(hist[1].a2, 2)));
        chk("fwd_rt_M", 8'(fwd_rt_M), 8'(pick(hist[2].a2, 3)));
    endtask

    function automatic void advance(input int a1, input int a2, input int a3, input int tn, input bit s);
        hist[3] = hist[2];
        hist[2] = hist[1];
        if (s) hist[1] = '{0, 0, 0, 0};
        else   hist[1] = '{a1, a2, a3, tn};
    endfunction

    // Present one instruction in D and hold it until it leaves D
    task automatic step(input int a1, input int a2, input int a3,
                        input int u1, input int u2, input int tn, output int stalls);
        bit s;
        stalls = 0;
        A1_D = 5'(a1); A2_D = 5'(a2); A3_D = 5'(a3);
        Tuse1_D = 3'(u1); Tuse2_D = 3'(u2); Tnew_D = 3'(tn);
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            check_all(a1, a2, u1, u2, s);
            smp_stall = stall;
            smp_rsD = fwd_rs_D; smp_rtD = fwd_rt_D;
            smp_rsE = fwd_rs_E; smp_rtE = fwd_rt_E; smp_rtM = fwd_rt_M;
            @(posedge clk);
            advance(a1, a2, a3, tn, s);
            #1;
            if (!s) break;
            stalls++;
        end
        chk("stall_bound", 8'(stalls < 8), 8'd1);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        A1_D = '0; A2_D = '0; A3_D = '0;
        Tuse1_D = '0; Tuse2_D = '0; Tnew_D = '0;
        repeat (cycles) @(posedge clk);
        clear_hist();
        #1 reset = 1'b0;
    endtask

    task automatic nops(input int n);
        int st;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, st);
    endtask

    initial begin
        int st;
        bit s;
        reset = 1'b1;
        clear_hist();

        // 1. reset, then addu $3,$1,$2
        do_reset(2);
        step(1, 2, 3, 1, 1, 1, st);
        chk("t1_stall", 8'(smp_stall), 8'd0);
        chk("t1_rsD",   8'(smp_rsD),   8'd0);
        chk("t1_rtD",   8'(smp_rtD),   8'd0);
        nops(3);

        // 2. addu $3 then addu $4,$3,$0; rs forwarded from M in E
        step(1, 2, 3, 1, 1, 1, st);
        step(3, 0, 4, 1, 1, 1, st);
        chk("t2_stalls", 8'(st), 8'd0);
        step(0, 0, 0, 0, 0, 0, st);
        chk("t2_rsE", 8'(smp_rsE), 8'd2);
        nops(3);

        // 3. lw $5 then beq $5,$0: two stall cycles, then W forward
        step(1, 0, 5, 1, 0, 2, st);
        step(5, 0, 0, 0, 0, 0, st);
        chk("t3_stalls", 8'(st), 8'd2);
        chk("t3_rsD",    8'(smp_rsD), 8'd1);
        nops(3);

        // 4. lw $6 then sw $6,0($7)
        step(1, 0, 6, 1, 0, 2, st);
        step(7, 6, 0, 1, 2, 0, st);
        chk("t4_stalls", 8'(st), 8'd0);
        step(0, 0, 0, 0, 0, 0, st);
        chk("t4_rtE", 8'(smp_rtE), 8'd0);
        step(0, 0, 0, 0, 0, 0, st);
        chk("t4_rtM", 8'(smp_rtM), 8'd1);
        nops(3);

        // 5. jal then jr $31, back-to-back and with one gap
        step(0, 0, 31, 0, 0, 0, st);
        step(31, 0, 0, 0, 0, 0, st);
        chk("t5_stalls", 8'(st), 8'd0);
        chk("t5_rsD_E",  8'(smp_rsD), 8'd3);
        step(0, 0, 31, 0, 0, 0, st);
        nops(1);
        step(31, 0, 0, 0, 0, 0, st);
        chk("t5_rsD_M",  8'(smp_rsD), 8'd2);
        nops(3);

        // 6. writers to $0 and a $0 consumer
        step(1, 2, 0, 1, 1, 1, st);
        step(1, 0, 0, 1, 0, 2, st);
        step(0, 0, 0, 0, 0, 0, st);
        chk("t6_stalls", 8'(st), 8'd0);
        chk("t6_rsD",    8'(smp_rsD), 8'd0);
        chk("t6_rtD",    8'(smp_rtD), 8'd0);

        // 6b. reset in the middle of a lw stall
        step(1, 0, 5, 1, 0, 2, st);
        A1_D = 5'd5; A2_D = '0; A3_D = '0; Tuse1_D = '0; Tuse2_D = '0; Tnew_D = '0;
        @(negedge clk);
        check_all(5, 0, 0, 0, s);
        chk("t6_pre_stall", 8'(stall), 8'd1);
        reset = 1'b1;
        @(posedge clk);
        clear_hist();
        #1 reset = 1'b0;
        @(negedge clk);
        check_all(5, 0, 0, 0, s);
        chk("t6_post_stall", 8'(stall), 8'd0);
        chk("t6_post_rsD",   8'(fwd_rs_D), 8'd0);
        @(posedge clk);
        advance(5, 0, 0, 0, s);
        #1;

        // Random traffic over a small register set to provoke hazards
        for (int i = 0; i < 400; i++) begin
            int r1, r2, r3;
            if ($urandom_range(0, 39) == 0) do_reset(1);
            r1 = ($urandom_range(0, 9) == 0) ? 31 : int'($urandom_range(0, 3));
            r2 = int'($urandom_range(0, 3));
            r3 = ($urandom_range(0, 9) == 0) ? 31 : int'($urandom_range(0, 3));
            step(r1, r2, r3, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                 int'($urandom_range(0, 2)), st);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
